fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Instruction fetch sequencer in front of the InstructionMemory block: owns the PC, drives the memory address, and tracks the one-cycle synchronous read latency. Buffers fetched words in a 2-entry queue and presents {pc, instruction} to decode over a valid/ready handshake. Supports redirects for branches, jumps and exceptions, plus an out-of-range/misalignment fault stop.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, byte-address width
MEM_SIZE, 1024, instruction memory depth in words; legal PCs are 0 .. MEM_SIZE*4-4
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
fetch_en  in  1  level; allows new memory requests
redirect_valid  in  1  one-cycle pulse; reload PC and flush
redirect_pc  in  ADDR_WIDTH  target byte address
imem_addr  out  ADDR_WIDTH  address to InstructionMemory inst_addr; always equals pc_q
imem_rdata  in  DATA_WIDTH  InstructionMemory inst_rdata; valid the cycle after imem_addr
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  DATA_WIDTH  head instruction
inst_pc  out  ADDR_WIDTH  head byte address
fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (rst=1 at edge): pc_q=RESET_PC, state=IDLE, queue empty, inflight=0, fetch_fault=0, inst_valid=0, inst_data=0, inst_pc=0. Reset mid-operation discards queue and in-flight data with no exceptions.
- States:
  - IDLE: no issue. Go to RUN when fetch_en=1.
  - RUN: issue allowed. Go to IDLE when fetch_en=0. Go to FAULT on the fault conditions below.
  - FAULT: no issue, fetch_fault=1. Leave only on redirect_valid with an aligned target (go to RUN if fetch_en=1, else IDLE) or on rst.
- Issue: in RUN, issue = (pc_q < MEM_SIZE*4) && (count + inflight - pop < 2), where pop = inst_valid && inst_ready.
  - On issue: inflight_q<=1, ipc_q<=pc_q, pc_q<=pc_q+4 (modulo 2^ADDR_WIDTH).
  - Without issue: inflight_q<=0, pc_q holds. imem_addr stays at pc_q and the memory output is ignored.
- Range fault: in RUN with pc_q >= MEM_SIZE*4, there is no issue; next cycle state=FAULT and fetch_fault=1. Queued and in-flight words still drain normally.
- Capture: when inflight_q=1, {ipc_q, imem_rdata} is pushed into the queue at the end of that cycle.
- Latency: issue in cycle t → data valid in cycle t+1 → inst_valid in cycle t+2. Throughput is one instruction per cycle while inst_ready=1.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle are both performed. Overflow cannot occur because of the issue credit rule. Pop when empty is ignored.
- Handshake: while inst_valid=1 and inst_ready=0, inst_data and inst_pc hold stable. Only redirect or rst may drop inst_valid without a pop.
- Redirect (priority over issue, push and pop):
  - At the end of the cycle: queue flushed, inflight_q=0, any same-cycle push is discarded, pc_q<=redirect_pc.
  - inst_valid=0 in the next cycle. A pop in the redirect cycle still counts as accepted by decode.
  - If redirect_pc[1:0] != 0: state<=FAULT, fetch_fault=1, no fetch.
  - A redirect in IDLE loads the PC and the state stays IDLE.
- fetch_en low in RUN: issue stops immediately; any in-flight word is still captured.

Decomposition:
- fetch_pkg:
  - state enum {IDLE, RUN, FAULT}
  - INST_BYTES=4
  - typedef fetch_entry_t {pc, data} (parameterised widths via package localparams matching defaults)
- One sub-module, fetch_queue: 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head, valid.
  - Flush has priority over push.
  - Reset clears the queue.

Test Plan:
Memory is preloaded with word i = 0xA000_0000+i.
1. rst, then fetch_en=1, inst_ready=1 → inst_valid first rises 2 cycles after the first issue with pc=0x0/data=0xA0000000, then 0x4/0xA0000001, 0x8/0xA0000002 on consecutive cycles with no bubbles.
2. inst_ready=0 for 5 cycles mid-stream → count reaches 2, imem_addr frozen, head stable. On release the sequence continues contiguous (no gap, no duplicate PC).
3. redirect_valid with redirect_pc=0x100 while the queue is full → inst_valid=0 next cycle. The next emitted entry is pc=0x100/data=0xA0000040, followed by 0x104. No pre-redirect PCs appear.
4. redirect to 0xFF8 (MEM_SIZE=1024) → emits 0xFF8 and 0xFFC, then fetch_fault=1 and no further inst_valid. A subsequent redirect to 0x0 clears the fault and emits pc=0x0.
5. redirect_pc=0x102 → fetch_fault=1 the next cycle and no instruction is emitted. Redirect to 0x8 → resumes at pc=0x8.
6. rst pulsed while 2 entries are queued and one is in flight → next cycle inst_valid=0, imem_addr=RESET_PC, fetch_fault=0, state IDLE until fetch_en.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, data} pairs; slot0 is always the head.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         valid
);
  fetch_entry_t slot0, slot1;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // With one entry the new word becomes the head directly.
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign valid = (count != 2'd0);
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues one-cycle-latency memory reads and
// buffers returned words for decode over a valid/ready handshake.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          MEM_SIZE   = 1024,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_fault
);
  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT = ADDR_WIDTH'(MEM_SIZE * INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, ipc_q;
  logic                  inflight_q, fault_q;
  logic                  pop, in_range, issue;
  logic [2:0]            occupancy;
  logic [1:0]            count;
  fetch_entry_t          head, din;

  assign pop      = inst_valid && inst_ready;
  assign in_range = pc_q < PC_LIMIT;
  // Credit: queued + in-flight words after this cycle's pop must leave room.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && fetch_en && !redirect_valid && in_range
                 && (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= PC_INIT;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      if (!is_aligned(redirect_pc)) begin
        state_q <= FAULT;
        fault_q <= 1'b1;
      end else begin
        fault_q <= 1'b0;
        state_q <= (state_q == IDLE || !fetch_en) ? IDLE : RUN;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        ipc_q <= pc_q;
        pc_q  <= pc_q + ADDR_WIDTH'(INST_BYTES);
      end
      case (state_q)
        IDLE: if (fetch_en) state_q <= RUN;
        RUN: begin
          if (!fetch_en) begin
            state_q <= IDLE;
          end else if (!in_range) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end
        end
        FAULT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din = '{pc: ipc_q, data: imem_rdata};

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head),
    .valid (inst_valid)
  );

  assign imem_addr   = pc_q;
  assign inst_data   = head.data;
  assign inst_pc     = head.pc;
  assign fetch_fault = fault_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: transaction-level model of the emitted
// instruction stream plus directed cycle-accurate scenarios.
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_data, inst_pc;
  logic        inst_valid, fetch_fault;

  int tests = 0;
  int fails = 0;
  int accepted = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;

  // Synchronous-read instruction memory.
  always @(posedge clk)
    imem_rdata <= (imem_addr < 32'h1000) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: decode must see consecutive PCs from the last reset or
  // redirect target, each carrying its memory word, with stable heads.
  logic [31:0] exp_pc = 32'h0;
  logic        prev_rst = 1'b0, prev_redir = 1'b0, prev_mis = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_pc = 32'h0, prev_data = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc     = 32'h0;
      prev_rst   = 1'b1;
      prev_redir = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_rst) begin
        chk("after_rst_valid", 32'(inst_valid), 32'd0);
        chk("after_rst_fault", 32'(fetch_fault), 32'd0);
        chk("after_rst_addr", imem_addr, 32'h0);
      end
      if (prev_redir) begin
        chk("after_redir_valid", 32'(inst_valid), 32'd0);
        chk("after_redir_fault", 32'(fetch_fault), 32'(prev_mis));
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_data", inst_data, prev_data);
      end
      if (inst_valid) chk("pc_in_range", 32'(inst_pc < 32'h1000), 32'd1);
      if (inst_valid && inst_ready) begin
        chk("pop_pc", inst_pc, exp_pc);
        chk("pop_data", inst_data, 32'hA000_0000 + (exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_pc    = inst_pc;
      prev_data  = inst_data;
      prev_redir = redirect_valid;
      prev_mis   = redirect_pc[1:0] != 2'b00;
      if (redirect_valid) exp_pc = redirect_pc;
      prev_rst   = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(inst_valid), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] hold_addr, hold_pc;
  int          r;

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    step(); step();
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_data", inst_data, 32'h0);
    chk("reset_pc", inst_pc, 32'h0);
    chk("reset_fault", 32'(fetch_fault), 32'd0);
    chk("reset_addr", imem_addr, 32'h0);

    // Startup latency and back-to-back stream
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    step();
    chk("t1_c1_valid", 32'(inst_valid), 32'd0);
    chk("t1_c1_addr", imem_addr, 32'h0);
    step();
    chk("t1_c2_valid", 32'(inst_valid), 32'd0);
    chk("t1_c2_addr", imem_addr, 32'h4);
    step();
    chk("t1_first_valid", 32'(inst_valid), 32'd1);
    chk("t1_first_pc", inst_pc, 32'h0);
    chk("t1_first_data", inst_data, 32'hA000_0000);
    step();
    chk("t1_second_valid", 32'(inst_valid), 32'd1);
    chk("t1_second_pc", inst_pc, 32'h4);
    chk("t1_second_data", inst_data, 32'hA000_0001);
    step();
    chk("t1_third_pc", inst_pc, 32'h8);
    chk("t1_third_data", inst_data, 32'hA000_0002);
    repeat (3) step();

    // Back-pressure
    inst_ready = 1'b0;
    step(); step();
    hold_addr = imem_addr;
    hold_pc   = inst_pc;
    repeat (3) step();
    chk("t2_addr_frozen", imem_addr, hold_addr);
    chk("t2_head_stable", inst_pc, hold_pc);
    chk("t2_valid", 32'(inst_valid), 32'd1);

    // Redirect while full
    redirect(32'h100);
    chk("t3_flush_valid", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    wait_valid("t3_wait");
    chk("t3_pc0", inst_pc, 32'h100);
    chk("t3_data0", inst_data, 32'hA000_0040);
    step();
    chk("t3_pc1", inst_pc, 32'h104);
    chk("t3_data1", inst_data, 32'hA000_0041);

    // End of memory range
    redirect(32'hFF8);
    wait_valid("t4_wait");
    chk("t4_pc0", inst_pc, 32'hFF8);
    step();
    chk("t4_pc1", inst_pc, 32'hFFC);
    chk("t4_data1", inst_data, 32'hA000_03FF);
    step();
    chk("t4_end_valid", 32'(inst_valid), 32'd0);
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    repeat (3) step();
    chk("t4_still_idle", 32'(inst_valid), 32'd0);
    chk("t4_still_fault", 32'(fetch_fault), 32'd1);
    redirect(32'h0);
    chk("t4_fault_clear", 32'(fetch_fault), 32'd0);
    wait_valid("t4_wait_restart");
    chk("t4_restart_pc", inst_pc, 32'h0);

    // Misaligned redirect
    redirect(32'h102);
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    chk("t5_valid", 32'(inst_valid), 32'd0);
    repeat (4) step();
    chk("t5_no_emit", 32'(inst_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'h102);
    redirect(32'h8);
    wait_valid("t5_wait_resume");
    chk("t5_resume_pc", inst_pc, 32'h8);
    chk("t5_resume_data", inst_data, 32'hA000_0002);

    // Reset mid-stream
    inst_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; fetch_en = 1'b0; inst_ready = 1'b1;
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_fault", 32'(fetch_fault), 32'd0);
    repeat (3) step();
    chk("t6_idle_valid", 32'(inst_valid), 32'd0);
    chk("t6_idle_addr", imem_addr, 32'h0);
    fetch_en = 1'b1;
    wait_valid("t6_wait_restart");
    chk("t6_restart_pc", inst_pc, 32'h0);

    // Randomized traffic
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom % 400) == 0;
      fetch_en       = ($urandom % 12) != 0;
      inst_ready     = ($urandom % 4) != 0;
      redirect_valid = 1'b0;
      if (!rst && ($urandom % 40) == 0) begin
        redirect_valid = 1'b1;
        r = int'($urandom % 8);
        if (r < 5)       redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        else if (r == 5) redirect_pc = 32'hFF0 + 32'(4 * $urandom_range(0, 3));
        else if (r == 6) redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        else             redirect_pc = 32'h2000;
      end
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    chk("random_progress", 32'(accepted > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
